// File: rtl/mips_cpu_muldiv_ctrl.sv
// Iterative HI/LO multiply/divide sequencer: shift-add MULT/MULTU, restoring DIV/DIVU, one bit per cycle.
// Optional `MULDIV_EARLY_TERM_EN: multiplies stop once the remaining multiplier bits are zero.
module mips_cpu_muldiv_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_write,
    input  logic             lo_write,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned   CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP} state_t;

    state_t           state_q, state_d;
    logic             div_q, div_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] acc_q, acc_d;      // product high half / partial remainder
    logic [WIDTH-1:0] mq_q, mq_d;        // multiplier shifting out, quotient shifting in
    logic [WIDTH-1:0] opnd_q, opnd_d;    // |a| multiplicand or |b| divisor
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic               is_signed;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] prod_raw, prod;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        is_signed = ~op[0];
        mag_a     = (is_signed && a[WIDTH-1]) ? -a : a;
        mag_b     = (is_signed && b[WIDTH-1]) ? -b : b;
        mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q, mq_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        // remainder stays below the divisor, so the low WIDTH bits hold the full difference
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        prod_raw  = {acc_q, mq_q};
`ifdef MULDIV_EARLY_TERM_EN
        // a run stopped after count_q iterations lacks WIDTH-count_q pure shifts
        prod_raw  = prod_raw >> (CW'(WIDTH) - count_q);
`endif
        prod      = (sa_q ^ sb_q) ? -prod_raw : prod_raw;
        quo       = (sa_q ^ sb_q) ? -mq_q : mq_q;
        rem       = sa_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        count_d = count_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (hi_write) hi_d = wdata;
                if (lo_write) lo_d = wdata;
                if (start) begin
                    div_d   = op[1];
                    sa_d    = is_signed & a[WIDTH-1];
                    sb_d    = is_signed & b[WIDTH-1];
                    count_d = '0;
                    acc_d   = '0;
                    mq_d    = op[1] ? mag_a : mag_b;
                    opnd_d  = op[1] ? mag_b : mag_a;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (div_q) begin
                    acc_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
                    mq_d  = {mq_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
                end
                count_d = count_q + 1'b1;
                if (count_q == LAST) state_d = S_FIXUP;
`ifdef MULDIV_EARLY_TERM_EN
                if (!div_q && ((mq_d & ({WIDTH{1'b1}} >> count_d)) == '0)) state_d = S_FIXUP;
`endif
            end
            S_FIXUP: begin
                hi_d    = div_q ? rem : prod[2*WIDTH-1:WIDTH];
                lo_d    = div_q ? quo : prod[WIDTH-1:0];
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_FIXUP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            count_q <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (clk_enable) begin
            state_q <= state_d;
            div_q   <= div_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mips_cpu_muldiv_ctrl.sv
// Scoreboard bench for mips_cpu_muldiv_ctrl: directed ops push expected hi/lo/timing, a monitor checks on done.
module tb_mips_cpu_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_enable = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        hi_write = 1'b0;
    logic        lo_write = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    mips_cpu_muldiv_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start), .op(op),
        .a(a), .b(b), .hi_write(hi_write), .lo_write(lo_write), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;
`ifdef MULDIV_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   busy_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %08h want %08h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Multiply latency: full WIDTH iterations, or highest set bit of |b| (min 1) with early termination.
    function automatic int mul_lat(input logic [31:0] bmag);
        int n = 1;
        for (int i = 0; i < 32; i++) if (bmag[i]) n = i + 1;
        return EARLY ? n + 1 : 33;
    endfunction

    // Monitor: compares results, done timing and busy duration on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 want no pending op (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                check("hi", hi, e.hi);
                check("lo", lo, e.lo);
                check("done_cycle", cyc, e.cyc);
                check("busy_cycles", busy_run, e.lat);
            end
            busy_run = 0;
        end else if (busy) begin
            busy_run++;
        end else begin
            busy_run = 0;
        end
    end

    // Called at a negedge; the following posedge is E0.
    task automatic issue(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                         input logic [31:0] eh, input logic [31:0] el, input int lat, input bit push);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = aa;
        b     = bb;
        if (push) begin
            e.hi  = eh;
            e.lo  = el;
            e.cyc = cyc + 1 + lat;
            e.lat = lat;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout_done: got no done within %0d cycles want done", limit);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);

        // MTHI / MTLO in IDLE
        hi_write = 1'b1; wdata = 32'hAAAA5555;
        @(negedge clk);
        hi_write = 1'b0;
        check("mthi_hi", hi, 32'hAAAA5555);
        lo_write = 1'b1; wdata = 32'h12345678;
        @(negedge clk);
        lo_write = 1'b0;
        check("mtlo_lo", lo, 32'h12345678);
        check("mtlo_hi_kept", hi, 32'hAAAA5555);

        // MTHI together with start: write lands and the op launches
        hi_write = 1'b1; wdata = 32'h0BADF00D;
        issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, mul_lat(32'hFFFFFFFF), 1'b1);
        hi_write = 1'b0;
        check("start_mthi_hi", hi, 32'h0BADF00D);
        check("start_busy", {31'b0, busy}, 32'h1);
        wait_done(60);

        // Each following op starts in the done cycle of the previous one
        issue(MULT, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, mul_lat(32'h7), 1'b1);
        wait_done(60);
        issue(DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b1);
        wait_done(60);
        issue(DIVU, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 33, 1'b1);
        wait_done(60);
        issue(DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 1'b1);
        wait_done(60);
        issue(DIV, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'h00000001, 33, 1'b1);
        wait_done(60);

        // 1000/7 with writes at E5, start at E10, and 3 disabled cycles after E13
        issue(DIVU, 32'd1000, 32'd7, 32'd6, 32'd142, 36, 1'b1);
        repeat (4) @(negedge clk);
        hi_write = 1'b1; lo_write = 1'b1; wdata = 32'h00001234;
        @(negedge clk);
        hi_write = 1'b0; lo_write = 1'b0;
        check("busy_mtlo_ignored", lo, 32'h00000001);
        check("busy_mthi_ignored", hi, 32'hFFFFFFFB);
        repeat (4) @(negedge clk);
        start = 1'b1; op = MULTU; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_busy", {31'b0, busy}, 32'h1);
        repeat (3) @(negedge clk);
        clk_enable = 1'b0;
        repeat (3) @(negedge clk);
        clk_enable = 1'b1;
        wait_done(80);

        // Reset at E12 of a DIVU abandons it
        @(negedge clk);
        issue(DIVU, 32'hFFFFFFFF, 32'h00000003, 32'h0, 32'h0, 33, 1'b0);
        repeat (11) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_done", {31'b0, done}, 32'h0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        repeat (40) @(negedge clk);

        // Multiplies whose latency depends on early termination
        issue(MULTU, 32'd5, 32'd3, 32'h0, 32'h0000000F, mul_lat(32'd3), 1'b1);
        wait_done(60);
        issue(MULTU, 32'd1, 32'h80000000, 32'h0, 32'h80000000, mul_lat(32'h80000000), 1'b1);
        wait_done(60);
        issue(MULT, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, mul_lat(32'h0), 1'b1);
        wait_done(60);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish (errors=%0d of %0d checks)", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
